// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC, arbitrates ID jump / MEM branch redirects,
// holds a redirect pending while the hazard unit stalls PC updates, and freezes on halt.
module pc_redirect_unit #(
  parameter int                PC_W    = 32,
  parameter logic [PC_W-1:0]   PC_INIT = '0
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            pc_WEN,
  input  logic            id_jump_valid,
  input  logic [PC_W-1:0] id_jump_target,
  input  logic            mem_br_valid,
  input  logic [PC_W-1:0] mem_br_target,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic            npc_change,
  output logic [0:3]      flushes,
  output logic            halted
);

  typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_HALT} state_t;
  typedef enum logic {SRC_ID, SRC_MEM} src_t;

  localparam logic [0:3] MASK_ID  = 4'b1000;
  localparam logic [0:3] MASK_MEM = 4'b1100;

  state_t          state, state_d;
  src_t            pend_src, pend_src_d;
  logic [PC_W-1:0] pend_target, pend_target_d;
  logic [PC_W-1:0] pc_d;

  // Arbitration between simultaneous redirects: the older instruction (MEM) wins.
  logic            redirect;
  src_t            win_src;
  logic [PC_W-1:0] win_target;
  logic            overwrite;

  assign redirect   = mem_br_valid | id_jump_valid;
  assign win_src    = mem_br_valid ? SRC_MEM : SRC_ID;
  assign win_target = mem_br_valid ? mem_br_target : id_jump_target;
  // A pending jump is superseded only by a branch from the older MEM stage.
  assign overwrite  = mem_br_valid && (pend_src == SRC_ID);

  assign halted = (state == ST_HALT);

  // State, PC and pending-redirect registers.
  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_RUN;
      pc          <= PC_INIT;
      pend_src    <= SRC_ID;
      pend_target <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      pend_src    <= pend_src_d;
      pend_target <= pend_target_d;
    end
  end

  // Next-state, next-PC and redirect outputs; outputs never depend on pc_WEN.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d       = state;
    pc_d          = pc;
    pend_src_d    = pend_src;
    pend_target_d = pend_target;
    npc_change    = 1'b0;
    flushes       = 4'b0000;

    unique case (state)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (redirect) begin
          npc_change = 1'b1;
          flushes    = (win_src == SRC_MEM) ? MASK_MEM : MASK_ID;
          if (pc_WEN) begin
            pc_d = win_target;
          end else begin
            state_d       = ST_PEND;
            pend_src_d    = win_src;
            pend_target_d = win_target;
          end
        end else if (pc_WEN) begin
          pc_d = pc + PC_W'(4);
        end
      end

      ST_PEND: begin
        npc_change = 1'b1;
        flushes    = (pend_src == SRC_MEM) ? MASK_MEM : MASK_ID;
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (pc_WEN) begin
          pc_d    = overwrite ? mem_br_target : pend_target;
          state_d = ST_RUN;
        end else if (overwrite) begin
          pend_src_d    = SRC_MEM;
          pend_target_d = mem_br_target;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed self-checking bench for pc_redirect_unit.
module tb_pc_redirect_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_WEN;
  logic        id_jump_valid;
  logic [31:0] id_jump_target;
  logic        mem_br_valid;
  logic [31:0] mem_br_target;
  logic        halt_req;
  logic [31:0] pc;
  logic        npc_change;
  logic [0:3]  flushes;
  logic        halted;

  int total = 0;
  int bad   = 0;

  pc_redirect_unit #(.PC_W(32), .PC_INIT(32'h0000_0000)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .pc_WEN         (pc_WEN),
    .id_jump_valid  (id_jump_valid),
    .id_jump_target (id_jump_target),
    .mem_br_valid   (mem_br_valid),
    .mem_br_target  (mem_br_target),
    .halt_req       (halt_req),
    .pc             (pc),
    .npc_change     (npc_change),
    .flushes        (flushes),
    .halted         (halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    pc_WEN         = 1'b0;
    id_jump_valid  = 1'b0;
    id_jump_target = '0;
    mem_br_valid   = 1'b0;
    mem_br_target  = '0;
    halt_req       = 1'b0;
  endtask

  // Async reset pulse applied mid-cycle; checks outputs drop immediately.
  task automatic reset_pulse(input string tag);
    nRST = 1'b0;
    #1;
    check({tag, "_pc"},    pc, 32'h0);
    check({tag, "_npc"},   {31'b0, npc_change}, 32'h0);
    check({tag, "_fl"},    {28'b0, flushes}, 32'h0);
    check({tag, "_halt"},  {31'b0, halted}, 32'h0);
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    nRST = 1'b0;
    #1;
    check("rst_pc",   pc, 32'h0);
    check("rst_npc",  {31'b0, npc_change}, 32'h0);
    check("rst_fl",   {28'b0, flushes}, 32'h0);
    check("rst_halt", {31'b0, halted}, 32'h0);
    #11;
    nRST = 1'b1;

    // 1: sequential fetch
    pc_WEN = 1'b1;
    #1;
    check("seq_pc0", pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc",  pc, 32'(4 * i));
      check("seq_npc", {31'b0, npc_change}, 32'h0);
    end
    for (int i = 0; i < 13; i++) tick();
    check("seq_pc40", pc, 32'h40);

    // 2: branch redirect with pc_WEN
    mem_br_valid  = 1'b1;
    mem_br_target = 32'h100;
    #1;
    check("br_npc", {31'b0, npc_change}, 32'h1);
    check("br_fl",  {28'b0, flushes}, 32'hC);
    tick();
    mem_br_valid = 1'b0;
    #1;
    check("br_pc",   pc, 32'h100);
    check("br_npc0", {31'b0, npc_change}, 32'h0);

    // hold with no redirect and pc_WEN low
    pc_WEN = 1'b0;
    tick();
    check("hold_pc", pc, 32'h100);

    // 3: jump held pending across 3 stalled cycles
    id_jump_valid  = 1'b1;
    id_jump_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("jp_npc", {31'b0, npc_change}, 32'h1);
      check("jp_fl",  {28'b0, flushes}, 32'h8);
      check("jp_pc",  pc, 32'h100);
      tick();
    end
    pc_WEN = 1'b1;
    id_jump_valid = 1'b0;
    tick();
    check("jp_pc_taken", pc, 32'h200);
    check("jp_run_npc",  {31'b0, npc_change}, 32'h0);
    pc_WEN = 1'b0;

    // 4a: pending ID overwritten by MEM branch
    id_jump_valid  = 1'b1;
    id_jump_target = 32'h200;
    tick();
    id_jump_valid = 1'b0;
    check("ow_fl_id", {28'b0, flushes}, 32'h8);
    mem_br_valid  = 1'b1;
    mem_br_target = 32'h300;
    tick();
    mem_br_valid = 1'b0;
    check("ow_fl_mem", {28'b0, flushes}, 32'hC);
    check("ow_pc_hold", pc, 32'h200);
    pc_WEN = 1'b1;
    tick();
    check("ow_pc", pc, 32'h300);
    check("ow_npc0", {31'b0, npc_change}, 32'h0);

    // 4b: simultaneous jump + branch in RUN, MEM wins
    id_jump_valid  = 1'b1;
    id_jump_target = 32'h500;
    mem_br_valid   = 1'b1;
    mem_br_target  = 32'h600;
    #1;
    check("both_fl", {28'b0, flushes}, 32'hC);
    tick();
    id_jump_valid = 1'b0;
    mem_br_valid  = 1'b0;
    pc_WEN        = 1'b0;
    check("both_pc", pc, 32'h600);

    // 4c: overwrite in the same cycle as pc_WEN
    id_jump_valid  = 1'b1;
    id_jump_target = 32'h700;
    tick();
    id_jump_valid = 1'b0;
    mem_br_valid  = 1'b1;
    mem_br_target = 32'h800;
    pc_WEN        = 1'b1;
    tick();
    mem_br_valid = 1'b0;
    pc_WEN       = 1'b0;
    check("ow_same_pc", pc, 32'h800);

    // 4d: pending MEM ignores later redirects
    mem_br_valid  = 1'b1;
    mem_br_target = 32'h900;
    tick();
    mem_br_target = 32'hA00;
    tick();
    mem_br_valid = 1'b0;
    pc_WEN = 1'b1;
    tick();
    pc_WEN = 1'b0;
    check("pmem_keep_pc", pc, 32'h900);

    // 5: halt beats a same-cycle branch, then sticky
    halt_req      = 1'b1;
    mem_br_valid  = 1'b1;
    mem_br_target = 32'hB00;
    pc_WEN        = 1'b1;
    #1;
    check("halt_fl",  {28'b0, flushes}, 32'h0);
    check("halt_npc", {31'b0, npc_change}, 32'h0);
    tick();
    halt_req = 1'b0;
    check("halt_pc",  pc, 32'h900);
    check("halt_on",  {31'b0, halted}, 32'h1);
    id_jump_valid  = 1'b1;
    id_jump_target = 32'hC00;
    tick();
    tick();
    check("halt_frozen_pc", pc, 32'h900);
    check("halt_sticky",    {31'b0, halted}, 32'h1);
    check("halt_npc_idle",  {31'b0, npc_change}, 32'h0);
    clear_inputs();
    #2;
    reset_pulse("halt_rst");

    // halt while pending drops the redirect
    id_jump_valid  = 1'b1;
    id_jump_target = 32'h40;
    tick();
    id_jump_valid = 1'b0;
    halt_req = 1'b1;
    pc_WEN   = 1'b1;
    tick();
    clear_inputs();
    check("phalt_pc",   pc, 32'h0);
    check("phalt_on",   {31'b0, halted}, 32'h1);
    check("phalt_npc",  {31'b0, npc_change}, 32'h0);
    #2;
    reset_pulse("phalt_rst");

    // 6: wrap-around and async reset while pending
    mem_br_valid  = 1'b1;
    mem_br_target = 32'hFFFF_FFFC;
    pc_WEN        = 1'b1;
    tick();
    mem_br_valid = 1'b0;
    check("wrap_top", pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_zero", pc, 32'h0);
    pc_WEN         = 1'b0;
    id_jump_valid  = 1'b1;
    id_jump_target = 32'h1234_5670;
    tick();
    id_jump_valid = 1'b0;
    check("pend_npc", {31'b0, npc_change}, 32'h1);
    #2;
    reset_pulse("pend_rst");
    pc_WEN = 1'b1;
    tick();
    check("pend_discard_pc", pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
